// File: rtl/j1_dbus_wb_master_pkg.sv
// Shared types for the J1 data-bus to Wishbone bridge.
package j1_dbus_wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  localparam logic [1:0] WB_SEL_ALL = 2'b11;

endpackage

// File: rtl/j1_dbus_wb_master.sv
// J1 data bus to Wishbone B4 classic master; stalls the core until ack/err.
// Optional watchdog: define J1_WB_TIMEOUT_EN to end a BUSY cycle after TIMEOUT cycles.
module j1_dbus_wb_master
  import j1_dbus_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dbus_adr,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [15:0] dbus_dat_o,
  output logic [15:0] dbus_dat_i,
  output logic        stall,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("TIMEOUT must be in 2..65535");
  end

  wb_state_t state;
  logic      req;
  logic      wd_expire;

  assign req      = dbus_re | dbus_we;
  assign wb_sel_o = WB_SEL_ALL;

`ifdef J1_WB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Zero in every non-BUSY cycle, so the first BUSY cycle always sees 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == BUSY) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expire = (wd_cnt == 16'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Depends only on state and the core request: no ack-to-core path.
  always_comb begin
    stall = 1'b0;
    if (state == BUSY || (state == IDLE && req)) begin
      stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      dbus_dat_i <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state    <= BUSY;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= dbus_we;
            wb_adr_o <= dbus_adr;
            wb_dat_o <= dbus_dat_o;
          end
        end
        BUSY: begin
          if (wb_err_i || wd_expire) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            bus_err  <= 1'b1;
            if (!wb_we_o) begin
              dbus_dat_i <= '0;
            end
          end else if (wb_ack_i) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (!wb_we_o) begin
              dbus_dat_i <= wb_dat_i;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j1_dbus_wb_master.sv
// Self-checking bench for j1_dbus_wb_master with a read-data scoreboard.
module tb_j1_dbus_wb_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dbus_adr;
  logic        dbus_re;
  logic        dbus_we;
  logic [15:0] dbus_dat_o;
  logic [15:0] dbus_dat_i;
  logic        stall;
  logic        bus_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [15:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd;
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  j1_dbus_wb_master #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dbus_adr   (dbus_adr),
    .dbus_re    (dbus_re),
    .dbus_we    (dbus_we),
    .dbus_dat_o (dbus_dat_o),
    .dbus_dat_i (dbus_dat_i),
    .stall      (stall),
    .bus_err    (bus_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dbus_adr = '0; dbus_re = 1'b0; dbus_we = 1'b0; dbus_dat_o = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    last_rd = '0;
    #2;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall});
    end
    n_checks++;
    if ({wb_adr_o, wb_dat_o, dbus_dat_i} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {wb_adr_o, wb_dat_o, dbus_dat_i});
    end
    n_checks++;
    if (wb_sel_o !== 2'b11) begin
      n_fail++; $display("FAIL sel: got %b expected 11", wb_sel_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_read();
    dbus_re = 1'b1; dbus_adr = 16'h1234;
    exp_q.push_back(16'hBEEF);
    #1;
    n_checks++;
    if ({stall, wb_cyc_o} !== 2'b10) begin
      n_fail++; $display("FAIL zw_t0: stall,cyc got %b expected 10", {stall, wb_cyc_o});
    end
    tick();
    n_checks++;
    if ({stall, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o} !== {4'b1110, 16'h1234}) begin
      n_fail++; $display("FAIL zw_t1: got %b/%h expected 1110/1234", {stall, wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o);
    end
    wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_checks++;
    if (dbus_dat_i !== exp_v) begin
      n_fail++; $display("FAIL zw_data: got %h expected %h", dbus_dat_i, exp_v);
    end
    n_checks++;
    if ({stall, wb_cyc_o, wb_stb_o, bus_err} !== 4'b0) begin
      n_fail++; $display("FAIL zw_t2: got %b expected 0000", {stall, wb_cyc_o, wb_stb_o, bus_err});
    end
    dbus_re = 1'b0;
    tick();
    n_checks++;
    if ({stall, wb_cyc_o} !== 2'b00) begin
      n_fail++; $display("FAIL zw_t3: got %b expected 00", {stall, wb_cyc_o});
    end
  endtask

  task automatic test_write_wait();
    dbus_we = 1'b1; dbus_adr = 16'h0010; dbus_dat_o = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({stall, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {4'b1111, 16'h0010, 16'hA5A5}) begin
        n_fail++; $display("FAIL wr_busy%0d: got %b/%h/%h expected 1111/0010/a5a5", i,
                           {stall, wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_dat_o);
      end
      if (i == 3) wb_ack_i = 1'b1;
    end
    tick();
    wb_ack_i = 1'b0;
    dbus_we = 1'b0;
    n_checks++;
    if ({stall, wb_cyc_o, wb_we_o, bus_err} !== 4'b0) begin
      n_fail++; $display("FAIL wr_done: got %b expected 0000", {stall, wb_cyc_o, wb_we_o, bus_err});
    end
    n_checks++;
    if (dbus_dat_i !== last_rd) begin
      n_fail++; $display("FAIL wr_rdata_kept: got %h expected %h", dbus_dat_i, last_rd);
    end
    tick();
    n_checks++;
    if ({wb_adr_o, wb_dat_o} !== {16'h0010, 16'hA5A5}) begin
      n_fail++; $display("FAIL wr_hold: got %h/%h expected 0010/a5a5", wb_adr_o, wb_dat_o);
    end
  endtask

  task automatic test_err_read();
    dbus_re = 1'b1; dbus_adr = 16'h0042;
    exp_q.push_back(16'h0000);
    tick();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 16'hFFFF;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 16'h0000;
    dbus_re = 1'b0;
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_checks++;
    if (dbus_dat_i !== exp_v) begin
      n_fail++; $display("FAIL err_data: got %h expected %h", dbus_dat_i, exp_v);
    end
    n_checks++;
    if ({bus_err, stall, wb_cyc_o} !== 3'b100) begin
      n_fail++; $display("FAIL err_pulse: got %b expected 100", {bus_err, stall, wb_cyc_o});
    end
    tick();
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_end: got %b expected 0", bus_err);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned cyc_cnt;
    cyc_cnt = 0;
    dbus_re = 1'b1; dbus_adr = 16'h0100;
    exp_q.push_back(16'h1111);
    tick();
    if (wb_cyc_o) cyc_cnt++;
    wb_ack_i = 1'b1; wb_dat_i = 16'h1111;
    tick();
    wb_ack_i = 1'b0;
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_checks++;
    if (dbus_dat_i !== exp_v) begin
      n_fail++; $display("FAIL b2b_data0: got %h expected %h", dbus_dat_i, exp_v);
    end
    dbus_adr = 16'h0200;
    exp_q.push_back(16'h2222);
    #1;
    n_checks++;
    if ({stall, wb_cyc_o} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_done_ignored: got %b expected 00", {stall, wb_cyc_o});
    end
    tick();
    n_checks++;
    if ({stall, wb_cyc_o} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_idle_accept: got %b expected 10", {stall, wb_cyc_o});
    end
    tick();
    if (wb_cyc_o) cyc_cnt++;
    n_checks++;
    if (wb_adr_o !== 16'h0200) begin
      n_fail++; $display("FAIL b2b_adr1: got %h expected 0200", wb_adr_o);
    end
    wb_ack_i = 1'b1; wb_dat_i = 16'h2222;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
    dbus_re = 1'b0;
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_checks++;
    if (dbus_dat_i !== exp_v || stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_data1: got %h/%b expected %h/0", dbus_dat_i, stall, exp_v);
    end
    n_checks++;
    if (cyc_cnt !== 2) begin
      n_fail++; $display("FAIL b2b_cyc_count: got %0d expected 2", cyc_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    int unsigned cyc_cnt;
    cyc_cnt = 0;
    dbus_re = 1'b1; dbus_adr = 16'h0077;
`ifdef J1_WB_TIMEOUT_EN
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!wb_cyc_o) break;
      cyc_cnt++;
    end
    dbus_re = 1'b0;
    n_checks++;
    if (cyc_cnt !== 4) begin
      n_fail++; $display("FAIL to_cyc_len: got %0d expected 4", cyc_cnt);
    end
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_checks++;
    if ({bus_err, dbus_dat_i} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL to_end: got %b/%h expected 1/%h", bus_err, dbus_dat_i, exp_v);
    end
    tick();
    n_checks++;
    if ({bus_err, stall, wb_cyc_o} !== 3'b000) begin
      n_fail++; $display("FAIL to_idle: got %b expected 000", {bus_err, stall, wb_cyc_o});
    end
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      if (wb_cyc_o) cyc_cnt++;
    end
    n_checks++;
    if (cyc_cnt !== 120 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL to_disabled_hold: got %0d/%b expected 120/0", cyc_cnt, bus_err);
    end
    dbus_re = 1'b0;
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    last_rd = 16'h0000;
    tick();
`endif
  endtask

  task automatic test_reset_mid_busy();
    dbus_we = 1'b1; dbus_adr = 16'h0ABC; dbus_dat_o = 16'h5A5A;
    tick();
    n_checks++;
    if (wb_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: cyc got %b expected 1", wb_cyc_o);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    dbus_we = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 16'hDEAD;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    tick();
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall} !== 5'b0) begin
      n_fail++; $display("FAIL rst_after_ctrl: got %b expected 00000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall});
    end
    n_checks++;
    if ({wb_adr_o, wb_dat_o, dbus_dat_i} !== 48'h0) begin
      n_fail++; $display("FAIL rst_after_data: got %h expected 0", {wb_adr_o, wb_dat_o, dbus_dat_i});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_err_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
